// File: rtl/ddr_train_pkg.sv
// ddr_train_pkg: shared types and defaults for the DDR read-phase trainer
package ddr_train_pkg;
    localparam int PHASE_W = 3;
    typedef logic [PHASE_W-1:0] phase_t;
    typedef enum logic [3:0] {
        IDLE, WAIT_LOCK, SAMPLE, WAIT_RESULT, STEP_HI, STEP_LO, SETTLE, EVAL, MOVE, DONE, FAIL
    } state_t;
    // what WAIT_LOCK hands over to once the PLL is locked
    typedef enum logic [1:0] {M_SWEEP, M_WRAP, M_MOVE} mode_t;
endpackage

// File: rtl/ddr_read_phase_trainer_if.sv
// ddr_read_phase_trainer_if: comparator and clocking-block signals of the trainer
interface ddr_read_phase_trainer_if;
    import ddr_train_pkg::*;
    logic pll_locked;
    logic sample_req;
    logic sample_valid;
    logic sample_pass;
    logic phase_step;
    logic phase_updn;
    modport master (
        input  pll_locked, sample_valid, sample_pass,
        output sample_req, phase_step, phase_updn
    );
    modport slave (
        output pll_locked, sample_valid, sample_pass,
        input  sample_req, phase_step, phase_updn
    );
endinterface

// File: rtl/ddr_train_window_finder.sv
// ddr_train_window_finder: sequential scan for the longest circular run of ones, 2*N cycles
module ddr_train_window_finder
    import ddr_train_pkg::*;
#(
    parameter int N_PHASES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_PHASES-1:0]         map,
    output logic                        done,
    output logic [$clog2(N_PHASES)-1:0] run_start,
    output logic [$clog2(N_PHASES):0]   run_len
);
    localparam int PW = $clog2(N_PHASES);
    localparam int LW = PW + 1;
    logic          busy, b, last;
    logic [PW:0]   idx, cur, cur_n;
    logic [PW-1:0] cs, cs_n;
    // two passes let a run crossing N-1 -> 0 be seen whole; strict '>' keeps the earliest start on ties
    always_comb begin
        b     = map[idx[PW-1:0]];
        cur_n = !b ? '0 : (cur == LW'(N_PHASES)) ? cur : cur + 1'b1;
        cs_n  = (b && cur == '0) ? idx[PW-1:0] : cs;
        last  = idx == LW'(2 * N_PHASES - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            idx       <= '0;
            cur       <= '0;
            cs        <= '0;
            run_start <= '0;
            run_len   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy      <= 1'b1;
                idx       <= '0;
                cur       <= '0;
                cs        <= '0;
                run_start <= '0;
                run_len   <= '0;
            end else if (busy) begin
                idx <= idx + 1'b1;
                cur <= cur_n;
                cs  <= cs_n;
                if (cur_n > run_len) begin
                    run_len   <= cur_n;
                    run_start <= cs_n;
                end
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/ddr_read_phase_trainer.sv
// ddr_read_phase_trainer: sweeps PLL read phases, grades them, and steps to the widest window centre.
// Defining DDR_TRAIN_PASSMAP_EN adds the pass_map output port.
module ddr_read_phase_trainer
    import ddr_train_pkg::*;
#(
    parameter int N_PHASES          = 8,
    parameter int SAMPLES_PER_PHASE = 4,
    parameter int STEP_HIGH_CYC     = 4,
    parameter int SETTLE_CYC        = 64,
    parameter int MIN_WINDOW        = 2,
    parameter int RESULT_TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    ddr_read_phase_trainer_if.master    bus,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [$clog2(N_PHASES)-1:0] best_phase,
    output logic [$clog2(N_PHASES):0]   win_len
`ifdef DDR_TRAIN_PASSMAP_EN
    ,
    output logic [N_PHASES-1:0]         pass_map
`endif
);
    localparam int PW   = $clog2(N_PHASES);
    localparam int LW   = PW + 1;
    localparam int CW   = $clog2(SAMPLES_PER_PHASE + 1);
    localparam int TMAX = (RESULT_TIMEOUT > SETTLE_CYC)
                        ? ((RESULT_TIMEOUT > STEP_HIGH_CYC) ? RESULT_TIMEOUT : STEP_HIGH_CYC)
                        : ((SETTLE_CYC > STEP_HIGH_CYC) ? SETTLE_CYC : STEP_HIGH_CYC);
    localparam int TW   = $clog2(TMAX + 1);

    state_t              state, state_n;
    mode_t               mode, mode_n;
    logic [PW-1:0]       cur_phase, phase_n, nsw, nsw_n, best_n;
    logic [N_PHASES-1:0] map_q, map_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [TW-1:0]       tmr, tmr_n;
    logic [LW-1:0]       len_n, wf_len;
    logic [PW-1:0]       wf_run_start;
    logic                wf_start, wf_done;

    ddr_train_window_finder #(.N_PHASES(N_PHASES)) u_finder (
        .clk      (clk),
        .rst      (rst),
        .start    (wf_start),
        .map      (map_q),
        .done     (wf_done),
        .run_start(wf_run_start),
        .run_len  (wf_len)
    );

    assign bus.sample_req = state == SAMPLE;
    assign bus.phase_step = state == STEP_HI;
    assign bus.phase_updn = 1'b1;
    assign busy           = !(state == IDLE || state == DONE || state == FAIL);
    assign done           = state == DONE;
    assign error          = state == FAIL;
`ifdef DDR_TRAIN_PASSMAP_EN
    assign pass_map = map_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= M_SWEEP;
            cur_phase  <= '0;
            map_q      <= '0;
            cnt        <= '0;
            tmr        <= '0;
            nsw        <= '0;
            best_phase <= '0;
            win_len    <= '0;
        end else begin
            state      <= state_n;
            mode       <= mode_n;
            cur_phase  <= phase_n;
            map_q      <= map_n;
            cnt        <= cnt_n;
            tmr        <= tmr_n;
            nsw        <= nsw_n;
            best_phase <= best_n;
            win_len    <= len_n;
        end
    end

    always_comb begin
        state_n  = state;
        mode_n   = mode;
        phase_n  = cur_phase;
        map_n    = map_q;
        cnt_n    = cnt;
        tmr_n    = tmr + 1'b1;
        nsw_n    = nsw;
        best_n   = best_phase;
        len_n    = win_len;
        wf_start = 1'b0;
        case (state)
            IDLE, DONE, FAIL: if (start) begin
                state_n = WAIT_LOCK;
                mode_n  = M_SWEEP;
                map_n   = '0;
                cnt_n   = '0;
                nsw_n   = '0;
                best_n  = '0;
                len_n   = '0;
            end
            WAIT_LOCK: if (bus.pll_locked) begin
                state_n  = mode == M_SWEEP ? SAMPLE : mode == M_WRAP ? EVAL : MOVE;
                wf_start = mode == M_WRAP;
            end
            SAMPLE: begin
                tmr_n   = '0;
                state_n = bus.pll_locked ? WAIT_RESULT : WAIT_LOCK;
                cnt_n   = bus.pll_locked ? cnt : '0;
            end
            WAIT_RESULT: if (!bus.pll_locked) begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
            end else if (bus.sample_valid) begin
                if (bus.sample_pass && cnt != CW'(SAMPLES_PER_PHASE - 1)) begin
                    cnt_n   = cnt + 1'b1;
                    state_n = SAMPLE;
                end else begin
                    // a failing result grades the phase at once; reaching here with pass=1 means all passed
                    map_n[cur_phase] = bus.sample_pass;
                    cnt_n            = '0;
                    nsw_n            = nsw + 1'b1;
                    tmr_n            = '0;
                    state_n          = STEP_HI;
                    mode_n           = nsw == PW'(N_PHASES - 1) ? M_WRAP : M_SWEEP;
                end
            end else if (tmr == TW'(RESULT_TIMEOUT - 2)) begin
                state_n = FAIL;
            end
            STEP_HI: if (tmr == TW'(STEP_HIGH_CYC - 1)) begin
                tmr_n   = '0;
                phase_n = cur_phase + 1'b1;
                state_n = STEP_LO;
            end
            STEP_LO: if (tmr == TW'(STEP_HIGH_CYC - 1)) begin
                tmr_n   = '0;
                state_n = SETTLE;
            end
            SETTLE: if (tmr == TW'(SETTLE_CYC - 1)) state_n = WAIT_LOCK;
            EVAL: if (wf_done) begin
                len_n = wf_len;
                if (wf_len < LW'(MIN_WINDOW)) begin
                    state_n = FAIL;
                end else begin
                    best_n  = wf_run_start + wf_len[PW:1];
                    mode_n  = M_MOVE;
                    state_n = MOVE;
                end
            end
            MOVE: begin
                tmr_n   = '0;
                state_n = cur_phase == best_phase ? DONE : STEP_HI;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/ddr_read_phase_trainer.md
Name: ddr_read_phase_trainer

Overview:
Read-capture phase calibration sequencer; drives the phase_step/phase_updn inputs of the DDR clocking block to move clk_ddrRead.
- Sweeps all PLL read-clock phases and requests read-compare samples at each.
- Records a pass bitmap, finds the widest circular passing window, then steps the PLL to the window centre.
- Sits between the PHY read-data comparator and the DDR clocking block, in the same clk domain as the clocking block's step logic.

Parameters:
N_PHASES, 8, phase positions per revolution (45° each); power of two, matches the clocking block's 3-bit phase.
SAMPLES_PER_PHASE, 4, compare results required per phase; a phase passes only if all pass.
STEP_HIGH_CYC, 4, cycles phase_step is held high, then held low, per step.
SETTLE_CYC, 64, wait cycles after each step before locked is checked.
MIN_WINDOW, 2, minimum passing run length for success.
RESULT_TIMEOUT, 1024, max cycles from sample_req to sample_valid.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; same reset as the clocking block, so the PLL also returns to phase 0
start  in  1  pulse; begins training from IDLE, DONE or FAIL
pll_locked  in  1  locked from the clocking block
sample_req  out  1  one-cycle pulse; requests one read-compare burst
sample_valid  in  1  one-cycle result strobe
sample_pass  in  1  compare result, qualified by sample_valid
phase_step  out  1  step strobe to the clocking block, edge-detected there
phase_updn  out  1  step direction; always 1 (up)
busy  out  1  high in every state except IDLE, DONE and FAIL
done  out  1  level; training succeeded
error  out  1  level; training failed
best_phase  out  $clog2(N_PHASES)  selected centre phase
win_len  out  $clog2(N_PHASES)+1  selected window length

Behaviour:
Reset values: all outputs 0; cur_phase=0; pass map=0; state IDLE.

Phase tracking:
- cur_phase is a modulo-N_PHASES counter.
- It increments when each step's high phase ends.
- phase_updn is tied to 1. Every step is up, so wrap N-1→0 is natural.

States:
- IDLE: start → WAIT_LOCK. Clears pass map, done and error; sets cnt=0.
- WAIT_LOCK: waits for pll_locked=1 → SAMPLE.
- SAMPLE: pulses sample_req for 1 cycle → WAIT_RESULT; the timeout counter starts.
- WAIT_RESULT:
  - On sample_valid with pass=1 and fewer than SAMPLES_PER_PHASE results → SAMPLE.
  - On sample_valid with pass=0, or after SAMPLES_PER_PHASE results, the phase is graded; pass_map[cur_phase] is set only if all results passed.
  - After grading: if this was the sweep (phases 0..N-1), → STEP_HI; after phase N-1 the sweep is complete, the next step wraps cur_phase to 0, and the FSM then goes to EVAL.
  - Timeout expiry → FAIL.
- STEP_HI: phase_step=1 for STEP_HIGH_CYC cycles → STEP_LO.
- STEP_LO: phase_step=0 for STEP_HIGH_CYC cycles → SETTLE.
- SETTLE: waits SETTLE_CYC cycles → WAIT_LOCK.
- EVAL: the window finder scans for 2·N_PHASES cycles.
  - Result win_len < MIN_WINDOW → FAIL.
  - Otherwise best_phase = (run_start + win_len/2) mod N → MOVE.
- MOVE: issues best_phase further steps through the STEP_HI/STEP_LO/SETTLE/WAIT_LOCK path, with no sampling. When cur_phase == best_phase → DONE. best_phase=0 goes to DONE immediately.
- DONE / FAIL: hold done=1 or error=1, and best_phase/win_len, until start or rst.

Window rule:
- Longest circular run of 1s; ties go to the lowest run_start.
- All-pass gives run_start=0, len=N.

Boundaries:
- sample_valid outside WAIT_RESULT is ignored.
- pll_locked falling during SAMPLE or WAIT_RESULT → WAIT_LOCK; the current phase's sample count is discarded and sampling of that phase restarts.
- start while busy is ignored.
- rst mid-operation → immediate IDLE with reset values.
- sample_valid and timeout expiry in the same cycle: sample_valid wins.

Optional Feature:
Macro DDR_TRAIN_PASSMAP_EN.
- Defined: adds output port pass_map [N_PHASES-1:0], which exposes the recorded bitmap. It is valid from EVAL entry, held in DONE/FAIL, and cleared on start.
- Undefined: no port. The bitmap stays internal and behaviour is otherwise identical.

Decomposition:
- Package ddr_train_pkg holds:
  - the state enum typedef (IDLE, WAIT_LOCK, SAMPLE, WAIT_RESULT, STEP_HI, STEP_LO, SETTLE, EVAL, MOVE, DONE, FAIL);
  - a phase index typedef;
  - the PHASE_W = $clog2(N_PHASES) default constant.
- Sub-module ddr_train_window_finder:
  - a sequential circular scan over the bitmap;
  - inputs: start, map; outputs: done, run_start, run_len;
  - latency 2·N_PHASES cycles after start.

Test Plan:
1. Comparator passes phases 2–5 only → 12 phase_step rising edges, all with updn=1; best_phase=4, win_len=4, done=1.
2. Passes phases 6,7,0,1 → wrap window: run_start=6, win_len=4, best_phase=0; exactly 8 rising edges; done=1.
3. Only phase 3 passes, MIN_WINDOW=2 → error=1, done=0, 8 rising edges; with DDR_TRAIN_PASSMAP_EN, pass_map=8'b0000_1000.
4. All phases pass → win_len=8, best_phase=4, 12 rising edges. Separately, phase 5 returns pass,pass,fail → phase 5 marked failed after only 3 sample_req pulses.
5. sample_valid withheld at phase 2 → error=1 exactly RESULT_TIMEOUT cycles after sample_req; busy=0.
6. Checks on stability and reset:
   - pll_locked dropped for 10 cycles during WAIT_RESULT at phase 1 → sampling of phase 1 restarts, with SAMPLES_PER_PHASE fresh sample_req pulses.
   - rst asserted mid-MOVE → next cycle all outputs 0 and state IDLE.
